// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types and constants for the BRAM write arbiter
package bram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_t;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    localparam int BCNT_W = 8;

endpackage

// File: rtl/bram_arb_sel.sv
// rtl/bram_arb_sel.sv - round-robin owner select with bounded burst hold
// Ports: aclk, aresetn (async active-low); a_valid, b_valid in;
//        owner (OWN_A/OWN_B), en (a beat is granted this cycle), busy (registered, state != IDLE) out.
module bram_arb_sel
    import bram_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic a_valid,
    input  logic b_valid,
    output logic owner,
    output logic en,
    output logic busy
);

    localparam logic [BCNT_W-1:0] MAX_B = BCNT_W'(MAX_BURST);

    arb_state_t        state, state_nxt;
    logic [BCNT_W-1:0] bcnt, bcnt_nxt;
    logic              last, last_nxt;
    logic              cur, cur_v, oth_v, hold, grant;

    always_comb begin
        owner     = last;
        grant     = 1'b0;
        hold      = 1'b0;
        cur       = OWN_A;
        cur_v     = 1'b0;
        oth_v     = 1'b0;
        state_nxt = IDLE;
        bcnt_nxt  = '0;
        last_nxt  = last;

        case (state)
            IDLE: begin
                if (a_valid && b_valid) begin
                    grant = 1'b1;
                    owner = ~last;
                end else if (a_valid || b_valid) begin
                    grant = 1'b1;
                    owner = b_valid ? OWN_B : OWN_A;
                end
            end
            GNT_A, GNT_B: begin
                cur   = (state == GNT_B) ? OWN_B : OWN_A;
                cur_v = (cur == OWN_B) ? b_valid : a_valid;
                oth_v = (cur == OWN_B) ? a_valid : b_valid;
                if (cur_v && (!oth_v || bcnt < MAX_B)) begin
                    grant = 1'b1;
                    hold  = 1'b1;
                    owner = cur;
                end else if (oth_v) begin
                    grant = 1'b1;
                    owner = ~cur;
                end
            end
            default: ;
        endcase

        if (grant) begin
            state_nxt = (owner == OWN_B) ? GNT_B : GNT_A;
            last_nxt  = owner;
            // Held grants count up and saturate; a new or switched grant restarts at 1.
            if (!hold)
                bcnt_nxt = BCNT_W'(1);
            else if (bcnt < MAX_B)
                bcnt_nxt = bcnt + BCNT_W'(1);
            else
                bcnt_nxt = bcnt;
        end

        // No beat may be granted while reset is asserted.
        en = grant & aresetn;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            bcnt  <= '0;
            last  <= OWN_B;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
            last  <= last_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

endmodule

// File: rtl/bram_write_arbiter.sv
// rtl/bram_write_arbiter.sv - two-requester write arbiter driving BRAM port A from registered outputs
// Ports: aclk, aresetn (async active-low); s_a_*/s_b_* addr/wdata/wstrb/valid in, ready out;
//        bram_porta_clk/rst/addr/wdata/we out; busy out.
// Optional macro BRAM_WRITE_ARBITER_CNT_EN adds cnt_a/cnt_b accepted-beat counters.
module bram_write_arbiter
    import bram_arb_pkg::*;
#(
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int MAX_BURST       = 4
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [BRAM_ADDR_WIDTH-1:0]   s_a_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]   s_a_wdata,
    input  logic [BRAM_DATA_WIDTH/8-1:0] s_a_wstrb,
    input  logic                         s_a_valid,
    output logic                         s_a_ready,
    input  logic [BRAM_ADDR_WIDTH-1:0]   s_b_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]   s_b_wdata,
    input  logic [BRAM_DATA_WIDTH/8-1:0] s_b_wstrb,
    input  logic                         s_b_valid,
    output logic                         s_b_ready,
    output logic                         bram_porta_clk,
    output logic                         bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
    output logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wdata,
    output logic [BRAM_DATA_WIDTH/8-1:0] bram_porta_we,
    output logic                         busy
`ifdef BRAM_WRITE_ARBITER_CNT_EN
    ,
    output logic [31:0]                  cnt_a,
    output logic [31:0]                  cnt_b
`endif
);

    logic owner;
    logic en;

    bram_arb_sel #(
        .MAX_BURST(MAX_BURST)
    ) u_sel (
        .aclk    (aclk),
        .aresetn (aresetn),
        .a_valid (s_a_valid),
        .b_valid (s_b_valid),
        .owner   (owner),
        .en      (en),
        .busy    (busy)
    );

    assign s_a_ready      = en & (owner == OWN_A) & s_a_valid;
    assign s_b_ready      = en & (owner == OWN_B) & s_b_valid;
    assign bram_porta_clk = aclk;
    assign bram_porta_rst = ~aresetn;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bram_porta_addr  <= '0;
            bram_porta_wdata <= '0;
            bram_porta_we    <= '0;
        end else if (en) begin
            bram_porta_addr  <= (owner == OWN_B) ? s_b_addr  : s_a_addr;
            bram_porta_wdata <= (owner == OWN_B) ? s_b_wdata : s_a_wdata;
            bram_porta_we    <= (owner == OWN_B) ? s_b_wstrb : s_a_wstrb;
        end else begin
            bram_porta_we    <= '0;
        end
    end

`ifdef BRAM_WRITE_ARBITER_CNT_EN
    logic [31:0] cnt_a_r, cnt_b_r;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_a_r <= '0;
            cnt_b_r <= '0;
        end else begin
            if (s_a_ready) cnt_a_r <= cnt_a_r + 32'd1;
            if (s_b_ready) cnt_b_r <= cnt_b_r + 32'd1;
        end
    end

    assign cnt_a = cnt_a_r;
    assign cnt_b = cnt_b_r;
`endif

endmodule

// File: tb/tb_bram_write_arbiter.sv
// tb/tb_bram_write_arbiter.sv - directed self-checking bench for bram_write_arbiter
module tb_bram_write_arbiter;

    logic        aclk;
    logic        aresetn;
    logic [9:0]  s_a_addr,  s_b_addr;
    logic [31:0] s_a_wdata, s_b_wdata;
    logic [3:0]  s_a_wstrb, s_b_wstrb;
    logic        s_a_valid, s_b_valid;
    logic        s_a_ready, s_b_ready;
    logic        bram_porta_clk, bram_porta_rst;
    logic [9:0]  bram_porta_addr;
    logic [31:0] bram_porta_wdata;
    logic [3:0]  bram_porta_we;
    logic        busy;
`ifdef BRAM_WRITE_ARBITER_CNT_EN
    logic [31:0] cnt_a, cnt_b;
`endif

    int vectors = 0;
    int errs    = 0;

    bram_write_arbiter #(
        .BRAM_DATA_WIDTH(32),
        .BRAM_ADDR_WIDTH(10),
        .MAX_BURST(4)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .s_a_addr         (s_a_addr),
        .s_a_wdata        (s_a_wdata),
        .s_a_wstrb        (s_a_wstrb),
        .s_a_valid        (s_a_valid),
        .s_a_ready        (s_a_ready),
        .s_b_addr         (s_b_addr),
        .s_b_wdata        (s_b_wdata),
        .s_b_wstrb        (s_b_wstrb),
        .s_b_valid        (s_b_valid),
        .s_b_ready        (s_b_ready),
        .bram_porta_clk   (bram_porta_clk),
        .bram_porta_rst   (bram_porta_rst),
        .bram_porta_addr  (bram_porta_addr),
        .bram_porta_wdata (bram_porta_wdata),
        .bram_porta_we    (bram_porta_we),
        .busy             (busy)
`ifdef BRAM_WRITE_ARBITER_CNT_EN
        ,
        .cnt_a            (cnt_a),
        .cnt_b            (cnt_b)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setab(input logic [9:0] aa, input logic [31:0] ad, input logic [3:0] as,
                         input logic [9:0] ba, input logic [31:0] bd, input logic [3:0] bs);
        s_a_addr = aa; s_a_wdata = ad; s_a_wstrb = as;
        s_b_addr = ba; s_b_wdata = bd; s_b_wstrb = bs;
    endtask

    // One clock: drive valids, check readies mid-cycle, then check the registered BRAM beat.
    task automatic cyc(input string tag, input logic av, input logic bv,
                       input logic era, input logic erb, input logic [3:0] ewe,
                       input logic [9:0] eaddr, input logic [31:0] edata);
        s_a_valid = av;
        s_b_valid = bv;
        @(negedge aclk);
        chk({tag, ".ready_a"}, 64'(s_a_ready), 64'(era));
        chk({tag, ".ready_b"}, 64'(s_b_ready), 64'(erb));
        @(posedge aclk);
        #1;
        chk({tag, ".we"},    64'(bram_porta_we),    64'(ewe));
        chk({tag, ".addr"},  64'(bram_porta_addr),  64'(eaddr));
        chk({tag, ".wdata"}, 64'(bram_porta_wdata), 64'(edata));
    endtask

    initial begin
        logic own_a;
        aresetn   = 1'b0;
        s_a_valid = 1'b1;
        s_b_valid = 1'b1;
        setab(10'd0, 32'h0, 4'hF, 10'd0, 32'h0, 4'hF);

        // Reset with both requesters valid
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst.ready_a", 64'(s_a_ready), 64'd0);
        chk("rst.ready_b", 64'(s_b_ready), 64'd0);
        chk("rst.we",      64'(bram_porta_we), 64'd0);
        chk("rst.busy",    64'(busy), 64'd0);
        chk("rst.addr",    64'(bram_porta_addr), 64'd0);
        chk("rst.bram_rst", 64'(bram_porta_rst), 64'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Contention for 12 cycles: AAAABBBBAAAA, a write every cycle
        for (int i = 0; i < 12; i++) begin
            own_a = (i < 4) || (i >= 8);
            setab(10'(10 + i), 32'hA000 + 32'(i), 4'hF, 10'(100 + i), 32'hB000 + 32'(i), 4'hF);
            cyc("cont", 1'b1, 1'b1, own_a, !own_a, 4'hF,
                own_a ? 10'(10 + i) : 10'(100 + i),
                own_a ? 32'hA000 + 32'(i) : 32'hB000 + 32'(i));
            if (i == 5) chk("cont.busy", 64'(busy), 64'd1);
        end
        cyc("cont_drop", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd21, 32'hA00B);
        chk("cont_drop.busy", 64'(busy), 64'd0);

        // A alone, three beats
        setab(10'd5, 32'h11, 4'hF, 10'd0, 32'h0, 4'hF);
        cyc("a_alone0", 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 10'd5, 32'h11);
        setab(10'd6, 32'h22, 4'hF, 10'd0, 32'h0, 4'hF);
        cyc("a_alone1", 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 10'd6, 32'h22);
        setab(10'd7, 32'h33, 4'hF, 10'd0, 32'h0, 4'hF);
        cyc("a_alone2", 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 10'd7, 32'h33);
        cyc("a_alone_idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd7, 32'h33);

        // Owner drops at bcnt = 2: B takes over that cycle and keeps its full burst
        setab(10'd40, 32'h40, 4'hF, 10'd50, 32'h50, 4'hF);
        cyc("drop_a0", 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 10'd40, 32'h40);
        setab(10'd41, 32'h41, 4'hF, 10'd50, 32'h50, 4'hF);
        cyc("drop_a1", 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 10'd41, 32'h41);
        cyc("drop_sw", 1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 10'd50, 32'h50);
        for (int i = 1; i < 4; i++) begin
            setab(10'd42, 32'h42, 4'h3, 10'(50 + i), 32'h50 + 32'(i), 4'hC);
            cyc("drop_b", 1'b1, 1'b1, 1'b0, 1'b1, 4'hC, 10'(50 + i), 32'h50 + 32'(i));
        end
        cyc("drop_back_a", 1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 10'd42, 32'h42);
        cyc("drop_idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd42, 32'h42);

        // Zero strobe beat is accepted but writes nothing
        setab(10'd9, 32'h99, 4'h0, 10'd0, 32'h0, 4'hF);
        cyc("zstrb", 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 10'd9, 32'h99);
        cyc("zstrb_idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd9, 32'h99);

        // Reset between a handshake and its write cycle
        setab(10'd3, 32'h3C, 4'hF, 10'd0, 32'h0, 4'hF);
        cyc("rmid_pre", 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 10'd3, 32'h3C);
        setab(10'd4, 32'h4C, 4'hF, 10'd0, 32'h0, 4'hF);
        @(negedge aclk);
        chk("rmid.ready_a", 64'(s_a_ready), 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("rmid.we_async", 64'(bram_porta_we), 64'd0);
        chk("rmid.ready_rst", 64'(s_a_ready), 64'd0);
        chk("rmid.busy_rst", 64'(busy), 64'd0);
        @(posedge aclk);
        #1;
        chk("rmid.we_edge", 64'(bram_porta_we), 64'd0);
        chk("rmid.addr", 64'(bram_porta_addr), 64'd0);
        s_a_valid = 1'b0;
        aresetn   = 1'b1;
        cyc("rmid_post", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        chk("rmid_post.busy", 64'(busy), 64'd0);
        // last is B again after reset, so a tie goes to A
        setab(10'd60, 32'h60, 4'hF, 10'd70, 32'h70, 4'hF);
        cyc("rmid_tie", 1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 10'd60, 32'h60);
        cyc("rmid_tie_idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd60, 32'h60);

`ifdef BRAM_WRITE_ARBITER_CNT_EN
        // Counters: 1 A beat already since reset, then 6 more A and 5 B
        for (int i = 0; i < 6; i++) begin
            setab(10'(200 + i), 32'(i), 4'hF, 10'd0, 32'h0, 4'hF);
            cyc("cnt_a", 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 10'(200 + i), 32'(i));
        end
        for (int i = 0; i < 5; i++) begin
            setab(10'd0, 32'h0, 4'hF, 10'(300 + i), 32'(i), 4'h1);
            cyc("cnt_b", 1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 10'(300 + i), 32'(i));
        end
        cyc("cnt_idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd304, 32'd4);
        chk("cnt_a.total", 64'(cnt_a), 64'd7);
        chk("cnt_b.total", 64'(cnt_b), 64'd5);
        dut.cnt_a_r = 32'hFFFF_FFFF;
        setab(10'd1, 32'h1, 4'hF, 10'd0, 32'h0, 4'hF);
        cyc("cnt_wrap", 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 10'd1, 32'h1);
        chk("cnt_a.wrap", 64'(cnt_a), 64'd0);
        s_a_valid = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/bram_write_arbiter.md
# bram_write_arbiter

Shares one BRAM write port (port A) between two independent write requesters, for example an AXI4-Lite BRAM writer and a stream-fed sample writer. Arbitration is round-robin with a bounded burst hold, so a requester cannot starve the other. The block sits between the requesters and the BRAM primitive. It drives the BRAM port from registered outputs at a sustained one beat per cycle.

## Interface
Parameters:
- BRAM_DATA_WIDTH, 32, BRAM word width; must be a multiple of 8.
- BRAM_ADDR_WIDTH, 10, BRAM word-address width.
- MAX_BURST, 4, consecutive beats the owner may keep the grant while the other requester waits; range 1..255.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous, active-low reset.
- s_a_addr  in  BRAM_ADDR_WIDTH  requester A word address.
- s_a_wdata  in  BRAM_DATA_WIDTH  requester A data.
- s_a_wstrb  in  BRAM_DATA_WIDTH/8  requester A byte enables.
- s_a_valid  in  1  requester A beat valid.
- s_a_ready  out  1  requester A beat accepted.
- s_b_addr, s_b_wdata, s_b_wstrb, s_b_valid, s_b_ready: same as the A signals, for requester B.
- bram_porta_clk  out  1  equals aclk.
- bram_porta_rst  out  1  equals ~aresetn.
- bram_porta_addr  out  BRAM_ADDR_WIDTH  registered address.
- bram_porta_wdata  out  BRAM_DATA_WIDTH  registered data.
- bram_porta_we  out  BRAM_DATA_WIDTH/8  registered byte write enables.
- busy  out  1  high while the FSM is not in IDLE.

## Operation
- FSM states are IDLE, GNT_A and GNT_B. A burst counter `bcnt` (8 bits) counts beats granted to the current owner.
- `last` register: records the most recent owner. Its reset value is B, so A wins the first tie.
- **IDLE:**
  - Only A valid: go to GNT_A.
  - Only B valid: go to GNT_B.
  - Both valid: grant the requester that is not `last`.
  - Neither valid: stay in IDLE.
  - The grant is decided in the same cycle as the request, so there is no idle-to-grant bubble.
- **GNT_X (owner X, other Y):** the grant is re-evaluated combinationally every cycle.
  - X keeps the grant while s_x_valid is high AND (Y is not valid OR bcnt < MAX_BURST).
  - The grant switches to Y in the same cycle when Y is valid AND (X is not valid OR bcnt == MAX_BURST). On a switch, bcnt reloads to 1 and `last` is set to Y.
  - Neither valid: go to IDLE and clear bcnt.
  - While Y is idle, bcnt saturates at MAX_BURST and X continues to hold the grant.
- **Ready and transfer:**
  - s_x_ready = (combinational owner == X) & s_x_valid.
  - Exactly one ready is high in any cycle, or none.
  - A beat transfers when valid & ready are both high.
- **Accepted beats:** each accepted beat registers {addr, wdata, wstrb} into the bram_porta_* outputs.
  - In a cycle with no accepted beat, bram_porta_we is 0; addr and wdata hold their previous values.
  - A beat with wstrb = 0 is still accepted and counted, and it produces bram_porta_we = 0.
- Write response and ordering belong to the requesters. This block never back-pressures indefinitely: the worst-case wait for a valid requester is MAX_BURST cycles.

## Timing
- **Reset values:**
  - s_a_ready = 0, s_b_ready = 0.
  - bram_porta_addr = 0, bram_porta_wdata = 0, bram_porta_we = 0.
  - busy = 0, state = IDLE, bcnt = 0, `last` = B.
- **Reset mid-operation:** an in-flight registered beat is dropped; bram_porta_we clears asynchronously.
- **Latency:** a handshake in cycle N produces the BRAM write strobe in cycle N+1, for exactly one cycle.
- **Throughput:** 1 beat per cycle, including the cycle in which ownership switches.
- s_x_ready may depend combinationally on s_a_valid and s_b_valid. The requesters must not make valid depend on ready.
- busy is a registered output reflecting the state.

## Configuration
- Macro: BRAM_WRITE_ARBITER_CNT_EN.
- **Defined:** adds outputs cnt_a and cnt_b (each 32 bits).
  - Each counts accepted beats of its requester and wraps modulo 2^32.
  - Both reset to 0.
  - An accepted beat is counted in the same cycle its BRAM strobe is registered.
- **Undefined:** the counter ports and the counter logic are absent. All other behaviour is identical.

## Structure
- **Package `bram_arb_pkg`:**
  - the state enum: IDLE = 2'd0, GNT_A = 2'd1, GNT_B = 2'd2;
  - the owner encoding: OWN_A = 1'b0, OWN_B = 1'b1;
  - the bcnt width constant (8).
- **Sub-module `bram_arb_sel`:**
  - contents: the FSM, bcnt and `last`;
  - inputs: the two valids;
  - outputs: the owner, its enable, and busy.
- The top level holds the datapath mux, the output registers and the optional counters.

## Test plan
- **Reset:** assert aresetn = 0 with A and B valid → readies = 0, we = 0, busy = 0; after release the first grant goes to A.
- **A alone:** 3 beats at addr 5, 6, 7 with data 0x11, 0x22, 0x33 and wstrb 0xF → we = 0xF in 3 consecutive cycles starting one cycle after the first handshake, matching addr/data.
- **Contention, MAX_BURST = 4:**
  - stimulus: A and B both held valid for 12 cycles;
  - required: grant order AAAABBBBAAAA, no bubble cycles, 12 BRAM writes.
- **Owner drops:** A owns with bcnt = 2 and deasserts valid while B is valid → B ready in that same cycle; A is re-granted only after B's burst.
- **Zero strobe and reset mid-op:**
  - A beat with wstrb = 0 → accepted and we = 0.
  - aresetn pulsed low between a handshake and its write cycle → no strobe; the FSM returns to IDLE.
- **CNT_EN build:** 7 A beats and 5 B beats → cnt_a = 7 and cnt_b = 5. Preload cnt_a = 0xFFFFFFFF, then 1 A beat → cnt_a = 0.
